vga_pixel_fetch: RTL and testbench
==================================

# vga_pixel_fetch

Display-side pixel fetch stage downstream of the VGA timing generator. It consumes the generator's `hen`/`ven`/`hs`/`vs`, produces synchronous-read addresses into the frame-buffer BRAM with integer upscaling (default 200x150 image shown on an 800x600 raster), and realigns sync and data-enable with the returned pixel data. The `rgb`, `hs_o`, `vs_o` and `de_o` outputs drive the VGA pins directly.

## Interface
- `H_DISP`, 800, active pixels per line.
- `V_DISP`, 600, active lines per frame.
- `SCALE_LOG2`, 2, log2 of the upscale factor, applied in both axes (2 gives 4x4).
- `ADDR_W`, 15, frame-buffer address width.
- `DATA_W`, 12, pixel width (RGB444).
- `clk`  in  1  pixel clock, same clock as the timing generator.
- `rstn`  in  1  reset, synchronous, active-low.
- `hen`  in  1  horizontal display enable from the timing generator.
- `ven`  in  1  vertical display enable from the timing generator.
- `hs`  in  1  horizontal sync, active-high.
- `vs`  in  1  vertical sync, active-high.
- `raddr`  out  ADDR_W  frame-buffer read address (registered).
- `rdata`  in  DATA_W  frame-buffer read data; BRAM has 1-cycle synchronous read latency.
- `rgb`  out  DATA_W  pixel out (registered); 0 whenever `de_o`=0.
- `hs_o`  out  1  `hs` delayed by 3 cycles.
- `vs_o`  out  1  `vs` delayed by 3 cycles.
- `de_o`  out  1  (`hen`&`ven`) delayed by 3 cycles.

## Operation
- active = `hen` & `ven`, sampled at each rising `clk`.
- Internal state:
  - `px` (0..H_DISP-1) and `py` (0..V_DISP-1): raster position.
  - `sx` and `sy` (0..2^SCALE_LOG2-1): sub-pixel counters.
  - `col` and `row_base`: ADDR_W wide.
- Image width in memory: IW = H_DISP>>SCALE_LOG2.
- Edge with active=1:
  - `raddr` <= `row_base` + `col`.
  - `px`++.
  - `sx`++; when `sx` wraps to 0, `col`++.
- Line end: active=1 at `px`=H_DISP-1, or a falling edge of `hen` while `ven`=1 and `px`!=0 (short line). At line end:
  - `px`, `sx` and `col` <= 0.
  - `py`++, `sy`++.
  - If `sy` wraps: `row_base` += IW. Otherwise `row_base` is unchanged, so the same image row is re-fetched.
  - Line end is processed once per line; a short line does not double-count.
- Frame restart: any edge with `vs`=1 clears `px`, `py`, `sx`, `sy`, `col` and `row_base`. `vs` takes priority over every other update in the same cycle.
- Edge with active=0 (and `vs`=0):
  - Counters hold.
  - `raddr` holds its last value; the memory read result is ignored.
- Address arithmetic: unsigned, truncated to ADDR_W. No wrap check; upstream guarantees IW*(V_DISP>>SCALE_LOG2) <= 2^ADDR_W.
- `rgb` <= `rdata` when the 2-cycle-delayed active is 1, else 0.
- Reset (`rstn`=0 at edge): all counters, `raddr`, `rgb`, `hs_o`, `vs_o` and `de_o` <= 0; all delay-line stages are also cleared. Reset mid-line or mid-frame discards the partial frame; fetch resumes at address 0 on the first active pixel after the next `vs`. If no `vs` occurs, it resumes from the cleared counters.

## Timing
- Pipeline for a pixel sampled active at edge k:
  - Edge k: `raddr` updated.
  - Edge k+1: BRAM captures `rdata`.
  - Edge k+2: `rgb` registered.
- `hs_o`, `vs_o` and `de_o` pass through a 3-stage delay (edges k, k+1, k+2). They are therefore cycle-aligned with `rgb`; total latency is 3 `clk` from input to pins.
- Throughput: 1 pixel per `clk`, no stalls, no backpressure.
- First active pixel of a frame: `raddr`=0. The last pixel of image row r is at address r*IW+IW-1.

## Configuration
- `VGA_PIXEL_FETCH_BORDER_EN`
  - Defined: `rgb` is forced to all-ones for pixels with `px`=0, `px`=H_DISP-1, `py`=0 or `py`=V_DISP-1. The border flag travels with the pixel through the same 2-stage delay as active. Addressing and latency are unchanged.
  - Undefined: `rgb` is always memory data (or 0 when blanked), and no border logic is synthesised.

## Test plan
- Reset: hold `rstn`=0 for 5 cycles with `hen`=`ven`=1 -> `raddr`, `rgb`, `hs_o`, `vs_o`, `de_o` all 0 throughout.
- Address sequence: first line after `vs`, defaults -> `raddr` = 0,0,0,0,1,1,1,1,...,199. Lines 1..3 repeat 0..199. Line 4 runs 200..399. Last line of the frame ends at 29999.
- Alignment: BRAM model with mem[a]=a[11:0] -> first `de_o`=1 exactly 3 cycles after the first active input, with `rgb`=0. `hs_o`/`vs_o` equal `hs`/`vs` delayed by 3.
- Blanking: `rdata` driven 12'hABC during `hen`=0 -> `rgb`=0 whenever `de_o`=0.
- Mid-frame events: assert `rstn`=0 for 1 cycle at line 300, then continue -> outputs 0 during reset. After the next `vs`, `raddr` restarts at 0. A short line (`hen` low after 500 pixels) advances `py` exactly once.
- Border (macro defined): full frame -> `rgb`=12'hFFF on line 0, line 599, column 0 and column 799; other pixels equal memory data.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: frame-buffer address generator with integer upscaling,
// realigning hs/vs/de with returned BRAM data. Option: VGA_PIXEL_FETCH_BORDER_EN.
module vga_pixel_fetch #(
   parameter int H_DISP     = 800,
   parameter int V_DISP     = 600,
   parameter int SCALE_LOG2 = 2,
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              hen,
   input  logic              ven,
   input  logic              hs,
   input  logic              vs,
   output logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] rgb,
   output logic              hs_o,
   output logic              vs_o,
   output logic              de_o
);

   localparam int PX_W = $clog2(H_DISP);
   localparam int PY_W = $clog2(V_DISP);
   localparam int S_W  = SCALE_LOG2;

   localparam logic [ADDR_W-1:0] IW      = ADDR_W'(H_DISP >> SCALE_LOG2);
   localparam logic [PX_W-1:0]   PX_LAST = PX_W'(H_DISP - 1);
   localparam logic [PY_W-1:0]   PY_LAST = PY_W'(V_DISP - 1);
   localparam logic [S_W-1:0]    S_MAX   = {S_W{1'b1}};

   logic              active;
   logic              line_end;

   logic [PX_W-1:0]   px_q, px_d;
   logic [PY_W-1:0]   py_q, py_d;
   logic [S_W-1:0]    sx_q, sx_d;
   logic [S_W-1:0]    sy_q, sy_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              hen_q;
   logic [2:0]        de_pipe_q;
   logic [2:0]        hs_pipe_q;
   logic [2:0]        vs_pipe_q;
   logic [DATA_W-1:0] rgb_q, rgb_d;
`ifdef VGA_PIXEL_FETCH_BORDER_EN
   logic              bor_d;
   logic [1:0]        bor_q;
`endif

   assign active = hen & ven;

   // Full line, or hen dropping early; px==0 means the line already ended.
   assign line_end = (active && (px_q == PX_LAST)) ||
                     (hen_q && !hen && ven && (px_q != '0));

   // Raster counters and fetch address; vs overrides everything.
   always_comb begin
      px_d       = px_q;
      py_d       = py_q;
      sx_d       = sx_q;
      sy_d       = sy_q;
      col_d      = col_q;
      row_base_d = row_base_q;
      raddr_d    = raddr_q;
      if (vs) begin
         px_d       = '0;
         py_d       = '0;
         sx_d       = '0;
         sy_d       = '0;
         col_d      = '0;
         row_base_d = '0;
      end else begin
         if (active) begin
            raddr_d = row_base_q + col_q;
            px_d    = px_q + PX_W'(1);
            sx_d    = sx_q + S_W'(1);
            if (sx_q == S_MAX) begin
               col_d = col_q + ADDR_W'(1);
            end
         end
         if (line_end) begin
            px_d  = '0;
            sx_d  = '0;
            col_d = '0;
            py_d  = (py_q == PY_LAST) ? '0 : py_q + PY_W'(1);
            sy_d  = sy_q + S_W'(1);
            if (sy_q == S_MAX) begin
               row_base_d = row_base_q + IW;
            end
         end
      end
   end

`ifdef VGA_PIXEL_FETCH_BORDER_EN
   // Border flag for the pixel being fetched this cycle.
   always_comb begin
      bor_d = (px_q == '0) || (px_q == PX_LAST) ||
              (py_q == '0) || (py_q == PY_LAST);
   end

   // Pixel output: border white, memory data, or black when blanked.
   always_comb begin
      rgb_d = '0;
      if (de_pipe_q[1]) begin
         rgb_d = bor_q[1] ? '1 : rdata;
      end
   end
`else
   // Pixel output: memory data, or black when blanked.
   always_comb begin
      rgb_d = '0;
      if (de_pipe_q[1]) begin
         rgb_d = rdata;
      end
   end
`endif

   // State registers and 3-stage sync/enable delay lines.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         px_q       <= '0;
         py_q       <= '0;
         sx_q       <= '0;
         sy_q       <= '0;
         col_q      <= '0;
         row_base_q <= '0;
         raddr_q    <= '0;
         hen_q      <= 1'b0;
         de_pipe_q  <= '0;
         hs_pipe_q  <= '0;
         vs_pipe_q  <= '0;
         rgb_q      <= '0;
`ifdef VGA_PIXEL_FETCH_BORDER_EN
         bor_q      <= '0;
`endif
      end else begin
         px_q       <= px_d;
         py_q       <= py_d;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
         col_q      <= col_d;
         row_base_q <= row_base_d;
         raddr_q    <= raddr_d;
         hen_q      <= hen;
         de_pipe_q  <= {de_pipe_q[1:0], active};
         hs_pipe_q  <= {hs_pipe_q[1:0], hs};
         vs_pipe_q  <= {vs_pipe_q[1:0], vs};
         rgb_q      <= rgb_d;
`ifdef VGA_PIXEL_FETCH_BORDER_EN
         bor_q      <= {bor_q[0], bor_d};
`endif
      end
   end

   assign raddr = raddr_q;
   assign rgb   = rgb_q;
   assign hs_o  = hs_pipe_q[2];
   assign vs_o  = vs_pipe_q[2];
   assign de_o  = de_pipe_q[2];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: scoreboard bench on a reduced 40x16 raster
// (4x upscale, 10x4 image) with a 1-cycle BRAM model mem[a]=a[11:0].
module tb_vga_pixel_fetch;

   localparam int H    = 40;
   localparam int V    = 16;
   localparam int S    = 2;
   localparam int AW   = 15;
   localparam int DW   = 12;
   localparam int HT   = H + 8;
   localparam int IW   = H >> S;
   localparam int LAST = IW * (V >> S) - 1;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic          hen  = 1'b0;
   logic          ven  = 1'b0;
   logic          hs   = 1'b0;
   logic          vs   = 1'b0;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata = '0;
   logic [DW-1:0] rgb;
   logic          hs_o;
   logic          vs_o;
   logic          de_o;
   logic          act_tb = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic          de;
      logic          hs;
      logic          vs;
      logic [DW-1:0] rgb;
   } exp_t;

   exp_t q[$];

   int   mx    = 0;
   int   my    = 0;
   logic m_hen = 1'b0;

   vga_pixel_fetch #(
      .H_DISP(H), .V_DISP(V), .SCALE_LOG2(S),
      .ADDR_W(AW), .DATA_W(DW)
   ) dut (
      .clk(clk), .rstn(rstn), .hen(hen), .ven(ven),
      .hs(hs), .vs(vs), .raddr(raddr), .rdata(rdata),
      .rgb(rgb), .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o)
   );

   always #5 clk = ~clk;

   // BRAM model: junk data when the fetch was not for an active pixel.
   always @(posedge clk) begin
      act_tb <= hen & ven;
      rdata  <= act_tb ? raddr[DW-1:0] : 12'hABC;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input logic r, input logic h, input logic v,
                       input logic hsi, input logic vsi);
      exp_t e;
      exp_t o;
      logic a;
      logic le;
      int   ea;
      rstn = r;
      hen  = h;
      ven  = v;
      hs   = hsi;
      vs   = vsi;
      a    = h & v;
      ea   = (my >> S) * IW + (mx >> S);
      e.de  = a;
      e.hs  = hsi;
      e.vs  = vsi;
      e.rgb = a ? DW'(ea) : '0;
`ifdef VGA_PIXEL_FETCH_BORDER_EN
      if (a && (mx == 0 || mx == H-1 || my == 0 || my == V-1))
         e.rgb = '1;
`endif
      if (!r) begin
         mx = 0;
         my = 0;
      end else if (vsi) begin
         mx = 0;
         my = 0;
      end else begin
         le = (a && mx == H-1) || (m_hen && !h && v && mx != 0);
         if (a) mx++;
         if (le) begin
            mx = 0;
            my = (my == V-1) ? 0 : my + 1;
         end
      end
      m_hen = r ? h : 1'b0;
      @(posedge clk);
      #1;
      if (!r) begin
         chk("rst_raddr", 32'(raddr), 0);
         chk("rst_rgb", 32'(rgb), 0);
         chk("rst_hs_o", 32'(hs_o), 0);
         chk("rst_vs_o", 32'(vs_o), 0);
         chk("rst_de_o", 32'(de_o), 0);
         q.delete();
         o = '{de: 1'b0, hs: 1'b0, vs: 1'b0, rgb: '0};
         q.push_back(o);
         q.push_back(o);
      end else begin
         if (a && !vsi) chk("raddr", 32'(raddr), 32'(ea));
         q.push_back(e);
         if (q.size() >= 3) begin
            o = q.pop_front();
            chk("de_o", 32'(de_o), 32'(o.de));
            chk("hs_o", 32'(hs_o), 32'(o.hs));
            chk("vs_o", 32'(vs_o), 32'(o.vs));
            chk("rgb", 32'(rgb), 32'(o.rgb));
         end
      end
   endtask

   task automatic frame(input int sl, input int slen, input int rl);
      int   len;
      logic hsv;
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < HT; c++)
            tick(1'b1, 1'b0, 1'b0, (c >= H+2 && c < H+5), 1'b1);
      for (int y = 0; y < V; y++) begin
         len = (y == sl) ? slen : H;
         for (int c = 0; c < HT; c++) begin
            hsv = (c >= H+2 && c < H+5);
            if (y == rl && c == 10) begin
               tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            end else begin
               tick(1'b1, (c < len), 1'b1, hsv, 1'b0);
               if (sl < 0 && rl < 0 && y == V-1 && c == H-1)
                  chk("last_addr", 32'(raddr), LAST);
            end
         end
      end
      for (int c = 0; c < HT; c++)
         tick(1'b1, 1'b0, 1'b0, (c >= H+2 && c < H+5), 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      frame(-1, 0, -1);
      frame(5, 22, -1);
      frame(-1, 0, 9);
      frame(-1, 0, -1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
